// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_ctrl_pkg;

    localparam int unsigned HZ_XLEN = 32;
    localparam int unsigned HZ_CNT_W = 32;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_counter.sv
// Free-running enable counter with synchronous reset; wraps at 2^32.
module hazard_stall_counter
    import hazard_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [HZ_CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use stalls, memory waits,
// taken-branch flushes and deferred redirects while a fetch is outstanding.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = HZ_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read_ex,
    input  logic [4:0]      rd_ex,
    input  logic [4:0]      rs1_id,
    input  logic [4:0]      rs2_id,
    input  logic            uses_rs1_id,
    input  logic            uses_rs2_id,
    input  logic            branch_taken_ex,
    input  logic [XLEN-1:0] branch_target_ex,
    input  logic            imem_ready,
    input  logic            mem_access_mem,
    input  logic            dmem_ready,
    output logic            pc_stall,
    output logic            if_id_stall,
    output logic            id_ex_stall,
    output logic            ex_mem_stall,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            mem_wb_flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            redirect_pending,
    output logic [31:0]     stall_cycles
);

    hz_state_t       state;
    logic [XLEN-1:0] tgt_q;
    logic            load_use;
    logic            d_busy;

    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((uses_rs1_id && (rd_ex == rs1_id)) ||
                       (uses_rs2_id && (rd_ex == rs2_id)));
    assign d_busy   = mem_access_mem && !dmem_ready;

    assign redirect_pending = (state == REDIR_PEND);

    // Strict priority: data freeze > pending replay > branch > load-use > fetch miss.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (d_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state == REDIR_PEND) begin
            if_id_flush = 1'b1;
            if (imem_ready) begin
                pc_redirect = 1'b1;
                pc_target   = tgt_q;
            end else begin
                pc_stall = 1'b1;
            end
        end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (imem_ready) begin
                pc_redirect = 1'b1;
                pc_target   = branch_target_ex;
            end else begin
                pc_stall = 1'b1;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            tgt_q <= '0;
        end else if (!d_busy) begin
            case (state)
                RUN: begin
                    if (branch_taken_ex && !imem_ready) begin
                        tgt_q <= branch_target_ex;
                        state <= REDIR_PEND;
                    end
                end
                REDIR_PEND: begin
                    if (imem_ready)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    hazard_stall_counter u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random cycles
// against a rule-level reference model.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read_ex;
    logic [4:0]  rd_ex;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        uses_rs1_id;
    logic        uses_rs2_id;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        imem_ready;
    logic        mem_access_mem;
    logic        dmem_ready;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        ex_mem_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        redirect_pending;
    logic [31:0] stall_cycles;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Reference model state.
    bit          m_pend;
    bit [31:0]   m_tgt;
    bit [31:0]   m_cnt;

    hazard_ctrl #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_ex      (mem_read_ex),
        .rd_ex            (rd_ex),
        .rs1_id           (rs1_id),
        .rs2_id           (rs2_id),
        .uses_rs1_id      (uses_rs1_id),
        .uses_rs2_id      (uses_rs2_id),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .imem_ready       (imem_ready),
        .mem_access_mem   (mem_access_mem),
        .dmem_ready       (dmem_ready),
        .pc_stall         (pc_stall),
        .if_id_stall      (if_id_stall),
        .id_ex_stall      (id_ex_stall),
        .ex_mem_stall     (ex_mem_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .mem_wb_flush     (mem_wb_flush),
        .pc_redirect      (pc_redirect),
        .pc_target        (pc_target),
        .redirect_pending (redirect_pending),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        rst              = 1'b0;
        mem_read_ex      = 1'b0;
        rd_ex            = 5'd0;
        rs1_id           = 5'd0;
        rs2_id           = 5'd0;
        uses_rs1_id      = 1'b0;
        uses_rs2_id      = 1'b0;
        branch_taken_ex  = 1'b0;
        branch_target_ex = 32'h0;
        imem_ready       = 1'b1;
        mem_access_mem   = 1'b0;
        dmem_ready       = 1'b1;
    endtask

    // Control bit order: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    //                     if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect}
    task automatic step(input string tag);
        bit [7:0]  e_ctrl;
        bit [31:0] e_tgt;
        bit        hazard;
        bit        dwait;
        logic [7:0] o_ctrl;
        #3;
        e_ctrl = 8'h00;
        e_tgt  = 32'h0;
        dwait  = mem_access_mem && !dmem_ready;
        hazard = mem_read_ex && rd_ex != 0 &&
                 ((uses_rs1_id && rd_ex == rs1_id) || (uses_rs2_id && rd_ex == rs2_id));
        if (rst) begin
            e_ctrl = 8'h00;
        end else if (dwait) begin
            e_ctrl = 8'b1111_0010;
        end else if (m_pend) begin
            if (imem_ready) begin e_ctrl = 8'b0000_1001; e_tgt = m_tgt; end
            else             e_ctrl = 8'b1000_1000;
        end else if (branch_taken_ex) begin
            if (imem_ready) begin e_ctrl = 8'b0000_1101; e_tgt = branch_target_ex; end
            else             e_ctrl = 8'b1000_1100;
        end else if (hazard) begin
            e_ctrl = 8'b1100_0100;
        end else if (!imem_ready) begin
            e_ctrl = 8'b1000_1000;
        end
        o_ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect};
        n_checks += 4;
        assert (o_ctrl === e_ctrl) else begin
            n_fails++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, o_ctrl, e_ctrl);
        end
        assert (pc_target === e_tgt) else begin
            n_fails++;
            $error("FAIL %s pc_target: observed %h expected %h", tag, pc_target, e_tgt);
        end
        assert (redirect_pending === m_pend) else begin
            n_fails++;
            $error("FAIL %s redirect_pending: observed %b expected %b", tag, redirect_pending, m_pend);
        end
        assert (stall_cycles === m_cnt) else begin
            n_fails++;
            $error("FAIL %s stall_cycles: observed %0d expected %0d", tag, stall_cycles, m_cnt);
        end
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0;
            m_tgt  = 32'h0;
            m_cnt  = 32'h0;
        end else begin
            m_cnt = m_cnt + 32'(e_ctrl[7]);
            if (!dwait) begin
                if (m_pend && imem_ready)
                    m_pend = 1'b0;
                else if (!m_pend && branch_taken_ex && !imem_ready) begin
                    m_pend = 1'b1;
                    m_tgt  = branch_target_ex;
                end
            end
        end
        #1;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        m_pend = 1'b0;
        m_tgt  = 32'h0;
        m_cnt  = 32'h0;
        @(posedge clk);
        #1;
        step("reset_hold");
        rst = 1'b0;
        step("idle");

        // Load-use hazard and its non-hazard variants.
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; uses_rs1_id = 1'b1;
        step("load_use");
        mem_read_ex = 1'b0;
        step("load_use_release");
        mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
        step("load_use_x0");
        rd_ex = 5'd5; rs1_id = 5'd5; uses_rs1_id = 1'b0;
        step("load_use_unused");
        set_idle();

        // Data wait with a branch held in EX.
        mem_access_mem = 1'b1; dmem_ready = 1'b0;
        branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0300;
        for (int i = 0; i < 3; i++) step("dwait_freeze");
        dmem_ready = 1'b1;
        step("dwait_release");
        set_idle();

        // Immediate branch.
        branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0100;
        step("branch_now");
        set_idle();

        // Pending redirect.
        branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0200; imem_ready = 1'b0;
        step("branch_pend_enter");
        branch_taken_ex = 1'b0; branch_target_ex = 32'h0;
        for (int i = 0; i < 2; i++) step("branch_pend_wait");
        imem_ready = 1'b1;
        step("branch_pend_fire");
        step("branch_pend_done");

        // Reset while pending drops the saved target.
        branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0400; imem_ready = 1'b0;
        step("rst_pend_enter");
        branch_taken_ex = 1'b0;
        rst = 1'b1;
        step("rst_pend_reset");
        rst = 1'b0; imem_ready = 1'b1;
        step("rst_pend_after");

        // Fetch miss alone.
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) step("fetch_miss");
        imem_ready = 1'b1;
        step("fetch_miss_done");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst              = ($urandom_range(0, 39) == 0);
            mem_read_ex      = 1'($urandom);
            rd_ex            = 5'($urandom_range(0, 3));
            rs1_id           = 5'($urandom_range(0, 3));
            rs2_id           = 5'($urandom_range(0, 3));
            uses_rs1_id      = 1'($urandom);
            uses_rs2_id      = 1'($urandom);
            branch_taken_ex  = ($urandom_range(0, 3) == 0);
            branch_target_ex = $urandom;
            imem_ready       = ($urandom_range(0, 2) != 0);
            mem_access_mem   = 1'($urandom);
            dmem_ready       = ($urandom_range(0, 2) != 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
